// File: rtl/priority_pkg.sv
// Shared types and defaults for the priority channel sequencer.
// Build option: PRIO_ROUND_ROBIN_EN selects round-robin start pointer instead of fixed priority.
package priority_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   localparam int N_CH_DEFAULT = 16;

endpackage

// File: rtl/priority_pick.sv
// Combinational find-first-set over a request mask, scanning upward from a start index with
// wrap past N_CH-1 back to 0. Produces one-hot, binary index and a found flag.
module priority_pick #(
   parameter int N_CH  = 16,
   parameter int IDX_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0]  pending,
   input  logic [IDX_W-1:0] start,
   output logic [N_CH-1:0]  onehot,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   always_comb begin : scan
      logic [IDX_W-1:0] j;
      onehot = '0;
      idx    = '0;
      found  = 1'b0;
      j      = '0;
      for (int k = 0; k < N_CH; k++) begin
         j = IDX_W'((int'(start) + k) % N_CH);
         if (!found && pending[j]) begin
            found     = 1'b1;
            idx       = j;
            onehot[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/priority_sequencer.sv
// Channel sequencer: captures a request mask on arm and presents one channel per dump.
// Build option: PRIO_ROUND_ROBIN_EN enables the round-robin start pointer (default fixed priority).
module priority_sequencer
   import priority_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int IDX_W = $clog2(N_CH)
) (
   input  logic             clk_i,
   input  logic             resetn_i,
   input  logic [N_CH-1:0]  ch_sel_i,
   input  logic             arm_i,
   input  logic             dump_i,
   input  logic             disable_i,
   output logic [N_CH-1:0]  ch_sel_o,
   output logic [IDX_W-1:0] ch_idx_o,
   output logic             valid_o,
   output logic             last_o,
   output logic             done_o,
   output logic             arm_err_o,
   output state_t           state_o
);

   // Handshake: arm_i is accepted only in IDLE with a non-zero mask; in ACTIVE each cycle
   // with dump_i high consumes exactly the presented channel; disable_i beats both.

   state_t            state, state_nxt;
   logic [N_CH-1:0]   pending, pending_nxt;
   logic              done_q, done_nxt;
   logic              arm_err_q, arm_err_nxt;
   logic [IDX_W-1:0]  start;
   logic [N_CH-1:0]   pick_onehot;
   logic [IDX_W-1:0]  pick_idx;
   logic              pick_found;
   logic              is_last;
   logic              active;

   priority_pick #(.N_CH(N_CH), .IDX_W(IDX_W)) u_pick (
      .pending (pending),
      .start   (start),
      .onehot  (pick_onehot),
      .idx     (pick_idx),
      .found   (pick_found)
   );

   // Exactly one bit left: clearing the lowest set bit leaves nothing.
   assign is_last = (pending != '0) && ((pending & (pending - N_CH'(1))) == '0);
   assign active  = (state == ACTIVE) && pick_found;

`ifdef PRIO_ROUND_ROBIN_EN
   logic [IDX_W-1:0] ptr, ptr_nxt;

   always_comb begin
      ptr_nxt = ptr;
      if (!disable_i && state == ACTIVE && dump_i) begin
         ptr_nxt = (pick_idx == IDX_W'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
      end
   end

   // Pointer persists across sequences; only reset clears it.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) ptr <= '0;
      else           ptr <= ptr_nxt;
   end

   assign start = ptr;
`else
   assign start = '0;
`endif

   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state     <= IDLE;
         pending   <= '0;
         done_q    <= 1'b0;
         arm_err_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         pending   <= pending_nxt;
         done_q    <= done_nxt;
         arm_err_q <= arm_err_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pending_nxt = pending;
      done_nxt    = 1'b0;
      arm_err_nxt = 1'b0;
      if (disable_i) begin
         state_nxt   = IDLE;
         pending_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               if (arm_i && (ch_sel_i != '0)) begin
                  pending_nxt = ch_sel_i;
                  state_nxt   = ACTIVE;
               end
            end
            ACTIVE: begin
               arm_err_nxt = arm_i;
               if (dump_i) begin
                  pending_nxt = pending & ~pick_onehot;
                  if (is_last) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                  end
               end
            end
            default: begin
               state_nxt   = IDLE;
               pending_nxt = '0;
            end
         endcase
      end
   end

   assign ch_sel_o  = active ? pick_onehot : '0;
   assign ch_idx_o  = active ? pick_idx : '0;
   assign valid_o   = active;
   assign last_o    = active && is_last;
   assign done_o    = done_q;
   assign arm_err_o = arm_err_q;
   assign state_o   = state;

endmodule
